serial_feeder: RTL and testbench

Parallel-to-serial stimulus stage that sits directly upstream of the two-input (E, x) state machine and drives its enable and data inputs. It accepts a WIDTH-bit word through a load/ready handshake and presents it one bit per clock on x, with E high for every valid bit. It inserts a programmable idle gap (E low) between words and supports a hold input that freezes the stream mid-word.

---
 rtl/serial_feeder_pkg.sv | 15 +
 rtl/feeder_shreg.sv | 51 +++++
 rtl/serial_feeder.sv | 123 ++++++++++++
 tb/tb_serial_feeder.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_feeder_pkg.sv
// Shared definitions for the serial_feeder block.
// Holds the FSM state encoding and the default word/gap sizes used as
// parameter defaults by serial_feeder and feeder_shreg.
package serial_feeder_pkg;

   localparam int unsigned DEF_WIDTH = 8;
   localparam int unsigned DEF_GAP   = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_GAP   = 2'b10
   } state_e;

endpackage

// File: rtl/feeder_shreg.sv
// Loadable shift register feeding the serial output of serial_feeder.
// The head bit is the bit currently presented; shifting moves the next
// bit into the head position.
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset, clears the register
//   load_i   capture din_i (takes priority over shift_i)
//   shift_i  advance one position toward the head
//   din_i    parallel word
//   head_o   current head bit (din_i[0] first, or din_i[WIDTH-1] when MSB_FIRST)
module feeder_shreg
   import serial_feeder_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned MSB_FIRST = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [WIDTH-1:0] din_i,
   output logic             head_o
);

   logic [WIDTH-1:0] sr_q;
   logic [WIDTH-1:0] sr_d;

   always_comb begin
      sr_d = sr_q;
      if (load_i) begin
         sr_d = din_i;
      end else if (shift_i) begin
         if (MSB_FIRST != 0) begin
            sr_d = {sr_q[WIDTH-2:0], 1'b0};
         end else begin
            sr_d = {1'b0, sr_q[WIDTH-1:1]};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign head_o = (MSB_FIRST != 0) ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/serial_feeder.sv
// Parallel-to-serial stimulus stage driving the enable (E) and data (x)
// inputs of a downstream two-input state machine. A word accepted through
// load/ready is presented one bit per clock with E=1, followed by GAP idle
// cycles with E=0. hold freezes the stream while shifting.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   din    WIDTH-bit word, sampled only on an accepted load
//   load   load request, accepted on a rising edge while ready=1
//   hold   pause request, effective only while shifting
//   ready  high in IDLE
//   E      high while shifting and hold=0
//   x      current serial bit, 0 outside SHIFT
//   done   high while the last bit is presented with E=1
//   busy   high in SHIFT and GAP
module serial_feeder
   import serial_feeder_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned GAP       = DEF_GAP,
   parameter int unsigned MSB_FIRST = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             load,
   input  logic             hold,
   output logic             ready,
   output logic             E,
   output logic             x,
   output logic             done,
   output logic             busy
);

   localparam int unsigned     CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);
   localparam logic [3:0]      GAP_LOAD = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

   state_e          state_q;
   state_e          state_d;
   logic [CW-1:0]   bit_q;
   logic [CW-1:0]   bit_d;
   logic [3:0]      gap_q;
   logic [3:0]      gap_d;
   logic            sr_load;
   logic            sr_shift;
   logic            head;

   feeder_shreg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shreg (
      .clk     (clk),
      .rst_n   (reset),
      .load_i  (sr_load),
      .shift_i (sr_shift),
      .din_i   (din),
      .head_o  (head)
   );

   always_comb begin
      state_d  = state_q;
      bit_d    = bit_q;
      gap_d    = gap_q;
      sr_load  = 1'b0;
      sr_shift = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (load) begin
               sr_load = 1'b1;
               bit_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            // hold freezes register, counter and state for this edge
            if (!hold) begin
               sr_shift = 1'b1;
               if (bit_q == LAST_BIT) begin
                  bit_d = '0;
                  if (GAP == 0) begin
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_GAP;
                     gap_d   = GAP_LOAD;
                  end
               end else begin
                  bit_d = bit_q + CW'(1);
               end
            end
         end
         ST_GAP: begin
            if (gap_q == 4'd0) begin
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q - 4'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         bit_q   <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         gap_q   <= gap_d;
      end
   end

   assign ready = (state_q == ST_IDLE);
   assign busy  = (state_q == ST_SHIFT) || (state_q == ST_GAP);
   assign E     = (state_q == ST_SHIFT) && !hold;
   assign done  = E && (bit_q == LAST_BIT);
   assign x     = (state_q == ST_SHIFT) && head;

endmodule

// File: tb/tb_serial_feeder.sv
// Directed testbench for serial_feeder. Four instances cover the
// configurations of interest: A (8,1,LSB), B (8,1,MSB), C (8,0,LSB),
// D (2,0,LSB). Observed outputs are packed as {ready,E,x,done,busy}.
module tb_serial_feeder;

   logic clk;
   logic reset;

   logic [7:0] a_din, b_din, c_din;
   logic [1:0] d_din;
   logic       a_load, b_load, c_load, d_load;
   logic       a_hold, b_hold, c_hold, d_hold;
   logic       a_ready, a_E, a_x, a_done, a_busy;
   logic       b_ready, b_E, b_x, b_done, b_busy;
   logic       c_ready, c_E, c_x, c_done, c_busy;
   logic       d_ready, d_E, d_x, d_done, d_busy;
   logic [4:0] a_obs, b_obs, c_obs, d_obs;

   int n_tests;
   int n_fail;

   assign a_obs = {a_ready, a_E, a_x, a_done, a_busy};
   assign b_obs = {b_ready, b_E, b_x, b_done, b_busy};
   assign c_obs = {c_ready, c_E, c_x, c_done, c_busy};
   assign d_obs = {d_ready, d_E, d_x, d_done, d_busy};

   serial_feeder #(.WIDTH(8), .GAP(1), .MSB_FIRST(0)) dut_a (
      .clk(clk), .reset(reset), .din(a_din), .load(a_load), .hold(a_hold),
      .ready(a_ready), .E(a_E), .x(a_x), .done(a_done), .busy(a_busy));

   serial_feeder #(.WIDTH(8), .GAP(1), .MSB_FIRST(1)) dut_b (
      .clk(clk), .reset(reset), .din(b_din), .load(b_load), .hold(b_hold),
      .ready(b_ready), .E(b_E), .x(b_x), .done(b_done), .busy(b_busy));

   serial_feeder #(.WIDTH(8), .GAP(0), .MSB_FIRST(0)) dut_c (
      .clk(clk), .reset(reset), .din(c_din), .load(c_load), .hold(c_hold),
      .ready(c_ready), .E(c_E), .x(c_x), .done(c_done), .busy(c_busy));

   serial_feeder #(.WIDTH(2), .GAP(0), .MSB_FIRST(0)) dut_d (
      .clk(clk), .reset(reset), .din(d_din), .load(d_load), .hold(d_hold),
      .ready(d_ready), .E(d_E), .x(d_x), .done(d_done), .busy(d_busy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #3;
      n_tests++;
      if (a_obs !== 5'b10000) begin
         n_fail++;
         $display("FAIL reset_a: got %b expected %b", a_obs, 5'b10000);
      end
      n_tests++;
      if (d_obs !== 5'b10000) begin
         n_fail++;
         $display("FAIL reset_d: got %b expected %b", d_obs, 5'b10000);
      end
      step();
      step();
      reset = 1'b1;
      #1;
      n_tests++;
      if (a_obs !== 5'b10000) begin
         n_fail++;
         $display("FAIL reset_release_a: got %b expected %b", a_obs, 5'b10000);
      end
   endtask

   task automatic test_lsb_first();
      logic [7:0] seq;
      logic [4:0] exp;
      seq = 8'b1010_0101;   // stream order, seq[i] is cycle i
      step();
      a_din = 8'hA5; a_load = 1'b1;
      #1;
      n_tests++;
      if (a_obs !== 5'b10000) begin
         n_fail++;
         $display("FAIL lsb_idle: got %b expected %b", a_obs, 5'b10000);
      end
      for (int i = 0; i < 8; i++) begin
         step();
         a_load = 1'b0; a_din = 8'h00;
         #1;
         exp = {1'b0, 1'b1, seq[i], (i == 7), 1'b1};
         n_tests++;
         if (a_obs !== exp) begin
            n_fail++;
            $display("FAIL lsb_bit%0d: got %b expected %b", i, a_obs, exp);
         end
      end
      step(); #1;
      n_tests++;
      if (a_obs !== 5'b00001) begin
         n_fail++;
         $display("FAIL lsb_gap: got %b expected %b", a_obs, 5'b00001);
      end
      step(); #1;
      n_tests++;
      if (a_obs !== 5'b10000) begin
         n_fail++;
         $display("FAIL lsb_ready: got %b expected %b", a_obs, 5'b10000);
      end
   endtask

   task automatic test_msb_first();
      logic [7:0] words [2];
      logic [7:0] seqs  [2];
      logic [4:0] exp;
      words[0] = 8'hA5; seqs[0] = 8'b1010_0101;
      words[1] = 8'h01; seqs[1] = 8'b1000_0000;   // seven zeros then a one
      for (int w = 0; w < 2; w++) begin
         step();
         b_din = words[w]; b_load = 1'b1;
         #1;
         for (int i = 0; i < 8; i++) begin
            step();
            b_load = 1'b0;
            #1;
            exp = {1'b0, 1'b1, seqs[w][i], (i == 7), 1'b1};
            n_tests++;
            if (b_obs !== exp) begin
               n_fail++;
               $display("FAIL msb_w%0d_bit%0d: got %b expected %b", w, i, b_obs, exp);
            end
         end
         step(); #1;
         n_tests++;
         if (b_obs !== 5'b00001) begin
            n_fail++;
            $display("FAIL msb_w%0d_gap: got %b expected %b", w, b_obs, 5'b00001);
         end
         step(); #1;
         n_tests++;
         if (b_obs !== 5'b10000) begin
            n_fail++;
            $display("FAIL msb_w%0d_ready: got %b expected %b", w, b_obs, 5'b10000);
         end
      end
   endtask

   task automatic test_hold();
      logic [4:0] exp_t [11];
      for (int c = 0; c < 4; c++)  exp_t[c] = 5'b01001;
      for (int c = 4; c < 7; c++)  exp_t[c] = 5'b00101;
      for (int c = 7; c < 10; c++) exp_t[c] = 5'b01101;
      exp_t[10] = 5'b01111;
      step();
      a_din = 8'hF0; a_load = 1'b1;
      #1;
      for (int c = 0; c < 11; c++) begin
         step();
         a_load = 1'b0;
         a_hold = (c >= 4 && c <= 6);
         #1;
         n_tests++;
         if (a_obs !== exp_t[c]) begin
            n_fail++;
            $display("FAIL hold_c%0d: got %b expected %b", c, a_obs, exp_t[c]);
         end
      end
      step(); #1;
      n_tests++;
      if (a_obs !== 5'b00001) begin
         n_fail++;
         $display("FAIL hold_gap: got %b expected %b", a_obs, 5'b00001);
      end
      step(); #1;
      n_tests++;
      if (a_obs !== 5'b10000) begin
         n_fail++;
         $display("FAIL hold_ready: got %b expected %b", a_obs, 5'b10000);
      end
   endtask

   task automatic test_hold_last();
      logic [4:0] exp_t [10];
      for (int c = 0; c < 4; c++) exp_t[c] = 5'b01001;
      for (int c = 4; c < 7; c++) exp_t[c] = 5'b01101;
      exp_t[7] = 5'b00101;
      exp_t[8] = 5'b00101;
      exp_t[9] = 5'b01111;
      step();
      a_din = 8'hF0; a_load = 1'b1;
      #1;
      for (int c = 0; c < 10; c++) begin
         step();
         a_load = 1'b0;
         a_hold = (c == 7 || c == 8);
         #1;
         n_tests++;
         if (a_obs !== exp_t[c]) begin
            n_fail++;
            $display("FAIL hold_last_c%0d: got %b expected %b", c, a_obs, exp_t[c]);
         end
      end
      // hold in GAP and IDLE must not stall anything
      step();
      a_hold = 1'b1;
      #1;
      n_tests++;
      if (a_obs !== 5'b00001) begin
         n_fail++;
         $display("FAIL hold_in_gap: got %b expected %b", a_obs, 5'b00001);
      end
      step(); #1;
      n_tests++;
      if (a_obs !== 5'b10000) begin
         n_fail++;
         $display("FAIL hold_gap_exit: got %b expected %b", a_obs, 5'b10000);
      end
      a_hold = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [7:0] seq;
      logic [4:0] exp;
      seq = 8'b0011_1100;   // 8'h3C LSB first: 0,0,1,1,1,1,0,0
      step();
      c_din = 8'h3C; c_load = 1'b1;
      #1;
      for (int i = 0; i < 8; i++) begin
         step(); #1;
         exp = {1'b0, 1'b1, seq[i], (i == 7), 1'b1};
         n_tests++;
         if (c_obs !== exp) begin
            n_fail++;
            $display("FAIL b2b_w0_bit%0d: got %b expected %b", i, c_obs, exp);
         end
      end
      step(); #1;
      n_tests++;
      if (c_obs !== 5'b10000) begin
         n_fail++;
         $display("FAIL b2b_idle_between: got %b expected %b", c_obs, 5'b10000);
      end
      for (int i = 0; i < 8; i++) begin
         step();
         if (i == 1) begin
            c_load = 1'b0; c_din = 8'hFF;
         end
         if (i == 4) c_load = 1'b1;
         if (i == 5) c_load = 1'b0;
         #1;
         exp = {1'b0, 1'b1, seq[i], (i == 7), 1'b1};
         n_tests++;
         if (c_obs !== exp) begin
            n_fail++;
            $display("FAIL b2b_w1_bit%0d: got %b expected %b", i, c_obs, exp);
         end
      end
      for (int j = 0; j < 3; j++) begin
         step(); #1;
         n_tests++;
         if (c_obs !== 5'b10000) begin
            n_fail++;
            $display("FAIL b2b_ignored_load%0d: got %b expected %b", j, c_obs, 5'b10000);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] seq;
      logic [4:0] exp;
      step();
      a_din = 8'hFF; a_load = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         step();
         a_load = 1'b0;
         #1;
         n_tests++;
         if (a_obs !== 5'b01001 + 5'b00100) begin
            n_fail++;
            $display("FAIL rmid_bit%0d: got %b expected %b", i, a_obs, 5'b01101);
         end
      end
      reset = 1'b0;
      #1;
      n_tests++;
      if (a_obs !== 5'b10000) begin
         n_fail++;
         $display("FAIL rmid_async: got %b expected %b", a_obs, 5'b10000);
      end
      step(); #1;
      n_tests++;
      if (a_obs !== 5'b10000) begin
         n_fail++;
         $display("FAIL rmid_held: got %b expected %b", a_obs, 5'b10000);
      end
      reset = 1'b1;
      seq = 8'b1001_0110;   // 8'h96 LSB first: 0,1,1,0,1,0,0,1
      step();
      a_din = 8'h96; a_load = 1'b1;
      #1;
      for (int i = 0; i < 8; i++) begin
         step();
         a_load = 1'b0;
         #1;
         exp = {1'b0, 1'b1, seq[i], (i == 7), 1'b1};
         n_tests++;
         if (a_obs !== exp) begin
            n_fail++;
            $display("FAIL rmid_new_bit%0d: got %b expected %b", i, a_obs, exp);
         end
      end
      step(); #1;
      n_tests++;
      if (a_obs !== 5'b00001) begin
         n_fail++;
         $display("FAIL rmid_gap: got %b expected %b", a_obs, 5'b00001);
      end
      step(); #1;
   endtask

   task automatic test_width2();
      logic [4:0] exp_t [3];
      exp_t[0] = 5'b01001;
      exp_t[1] = 5'b01111;
      exp_t[2] = 5'b10000;
      step();
      d_din = 2'b10; d_load = 1'b1;
      #1;
      n_tests++;
      if (d_obs !== 5'b10000) begin
         n_fail++;
         $display("FAIL w2_idle: got %b expected %b", d_obs, 5'b10000);
      end
      for (int c = 0; c < 3; c++) begin
         step();
         d_load = 1'b0;
         #1;
         n_tests++;
         if (d_obs !== exp_t[c]) begin
            n_fail++;
            $display("FAIL w2_c%0d: got %b expected %b", c, d_obs, exp_t[c]);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b0;
      a_din = '0; b_din = '0; c_din = '0; d_din = '0;
      a_load = 1'b0; b_load = 1'b0; c_load = 1'b0; d_load = 1'b0;
      a_hold = 1'b0; b_hold = 1'b0; c_hold = 1'b0; d_hold = 1'b0;
      test_reset();
      test_lsb_first();
      test_msb_first();
      test_hold();
      test_hold_last();
      test_back_to_back();
      test_reset_mid();
      test_width2();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
